// File: rtl/alu_pkg.sv
// Shared ALU definitions.
//   div_state_t : iterative divider FSM states
//   ALU_ADD/SUB : add/sub unit control encodings (SUB computes a + ~b + 1)
package alu_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;
endpackage

// File: rtl/add_sub_unit.sv
// N-bit ripple add/sub unit.
//   a, b    : operands
//   control : 0 = a + b, 1 = a + ~b + 1 (a - b)
//   y       : N-bit result
//   cout    : carry out; for subtraction 1 means no borrow (a >= b)
module add_sub_unit #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         control,
  output logic [N-1:0] y,
  output logic         cout
);
  logic [N-1:0] b_x;
  logic [N:0]   c;

  // control doubles as the carry-in, completing the two's complement of b
  assign c[0] = control;

  for (genvar i = 0; i < N; i++) begin : g_bit
    mux_not   u_inv (.a(b[i]), .sel(control), .y(b_x[i]));
    fulladder u_fa  (.a(a[i]), .b(b_x[i]), .cin(c[i]), .s(y[i]), .cout(c[i+1]));
  end

  assign cout = c[N];
endmodule

// File: rtl/fulladder.sv
// One-bit full adder.
//   a, b, cin : addends and carry in
//   s, cout   : sum and carry out
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/mux_not.sv
// Conditional inverter: y = sel ? ~a : a.
//   a   : data bit
//   sel : 1 = invert
//   y   : result
module mux_not (
  input  logic a,
  input  logic sel,
  output logic y
);
  assign y = sel ? ~a : a;
endmodule

// File: rtl/addsub_div_ctrl.sv
// Iterative unsigned restoring divider, one trial subtraction per clock
// through a shared add/sub unit.
//   clk, reset      : clock, synchronous active-high reset
//   start           : request, accepted only in IDLE
//   dividend/divisor: operands, captured on accepted start
//   busy            : division in progress (CALC)
//   done            : one-cycle pulse, results valid
//   quotient/remainder/div_by_zero : results, held until next accepted start
module addsub_div_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  div_state_t       state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d, r_q, r_d, d_q, d_d;
  logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   rs, diff;
  logic             no_borrow;
  logic [WIDTH-1:0] r_nxt, q_nxt;

  // Shift the next dividend bit into the partial remainder, then trial-subtract.
  assign rs = {r_q, q_q[WIDTH-1]};

  add_sub_unit #(.N(WIDTH + 1)) u_addsub (
    .a      (rs),
    .b      ({1'b0, d_q}),
    .control(ALU_SUB),
    .y      (diff),
    .cout   (no_borrow)
  );

  // Restoring step: keep the difference only when it did not borrow.
  assign r_nxt = no_borrow ? diff[WIDTH-1:0] : rs[WIDTH-1:0];
  assign q_nxt = {q_q[WIDTH-2:0], no_borrow};

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          q_d   = dividend;
          d_d   = divisor;
          r_d   = '0;
          cnt_d = '0;
          if (divisor != '0) begin
            state_d = CALC;
            dbz_d   = 1'b0;
          end else begin
            state_d = DONE;
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end
        end
      end
      CALC: begin
        q_d   = q_nxt;
        r_d   = r_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          quot_d  = q_nxt;
          rem_d   = r_nxt;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == CALC);
  assign done        = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_addsub_div_ctrl.sv
module tb_addsub_div_ctrl;
  localparam int W  = 32;
  localparam int WS = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start;
  logic [W-1:0]  dividend, divisor, quotient, remainder;
  logic          busy, done, dbz;

  logic          s_start;
  logic [WS-1:0] s_dividend, s_divisor, s_quotient, s_remainder;
  logic          s_busy, s_done, s_dbz;

  int n_cmp = 0;
  int n_err = 0;

  addsub_div_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(dbz)
  );

  addsub_div_ctrl #(.WIDTH(WS)) dut_s (
    .clk(clk), .reset(reset), .start(s_start), .dividend(s_dividend), .divisor(s_divisor),
    .busy(s_busy), .done(s_done), .quotient(s_quotient), .remainder(s_remainder),
    .div_by_zero(s_dbz)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One division on the 32-bit unit; operands are scrambled after acceptance.
  task automatic run32(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    logic [W-1:0] eq, er;
    int           lat;
    logic         busy_bad;
    if (b == '0) begin
      eq = '1; er = a;
    end else begin
      eq = a / b; er = a % b;
    end
    @(negedge clk); start = 1'b1; dividend = a; divisor = b;
    @(negedge clk); start = 1'b0; dividend = $urandom; divisor = $urandom;
    lat = 0; busy_bad = 1'b0;
    while (!done && lat < 100) begin
      if (busy !== (b != '0)) busy_bad = 1'b1;
      @(negedge clk); dividend = $urandom; divisor = $urandom;
      lat++;
    end
    chk({tag, ":latency"}, lat, (b == '0) ? 0 : W);
    chk({tag, ":busy"}, {busy_bad, busy}, 0);
    chk({tag, ":q"}, quotient, eq);
    chk({tag, ":r"}, remainder, er);
    chk({tag, ":dbz"}, dbz, (b == '0));
    @(negedge clk);
    chk({tag, ":pulse"}, {busy, done}, 0);
    chk({tag, ":held"}, {quotient, remainder}, {eq, er});
  endtask

  task automatic run4(input logic [WS-1:0] a, input logic [WS-1:0] b);
    logic [WS-1:0] eq, er;
    int            lat;
    if (b == '0) begin
      eq = '1; er = a;
    end else begin
      eq = a / b; er = a % b;
    end
    @(negedge clk); s_start = 1'b1; s_dividend = a; s_divisor = b;
    @(negedge clk); s_start = 1'b0;
    lat = 0;
    while (!s_done && lat < 20) begin
      @(negedge clk); lat++;
    end
    chk($sformatf("w4 %0d/%0d lat", a, b), lat, (b == '0) ? 0 : WS);
    chk($sformatf("w4 %0d/%0d res", a, b), {s_quotient, s_remainder, s_dbz},
        {eq, er, (b == '0)});
  endtask

  initial begin
    logic [W-1:0] x, y;
    int           ndone, last, gap_bad, k;
    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    s_start = 1'b0; s_dividend = '0; s_divisor = '0;
    repeat (3) @(negedge clk);
    chk("reset32", {busy, done, quotient, remainder, dbz}, 0);
    chk("reset4", {s_busy, s_done, s_quotient, s_remainder, s_dbz}, 0);
    reset = 1'b0;

    // Basic and boundary values
    run32(32'hFFFF_FFFF, 32'd1, "max/1");
    run32(32'd5, 32'd7, "5/7");
    run32(32'd7, 32'd7, "7/7");
    run32(32'd1234, 32'd0, "1234/0");
    run32(32'd100, 32'd7, "100/7");

    // Random operands; divisor shifted right by a random amount to span magnitudes
    for (int i = 0; i < 20; i++) begin
      x = $urandom;
      y = $urandom >> $urandom_range(0, 31);
      if (i % 7 == 3) y = '0;
      run32(x, y, $sformatf("rnd%0d", i));
    end

    // start held high: one done every W+2 cycles with fixed operands
    x = $urandom; y = ($urandom >> 20) | 32'd1;
    @(negedge clk); start = 1'b1; dividend = x; divisor = y;
    ndone = 0; last = -1; gap_bad = 0;
    for (int i = 0; i < 3 * (W + 2) + 4; i++) begin
      @(negedge clk);
      if (done) begin
        if (ndone > 0 && (i - last) != W + 2) gap_bad++;
        chk("held:q", {quotient, remainder}, {x / y, x % y});
        last = i; ndone++;
      end
    end
    start = 1'b0;
    chk("held:count", ndone, 3);
    chk("held:gap", gap_bad, 0);
    k = 0;
    while (!done && k < 100) begin
      @(negedge clk); k++;
    end
    chk("held:drain", k < 100, 1);
    @(negedge clk);

    // Reset in the middle of a division
    @(negedge clk); start = 1'b1; dividend = 32'd100; divisor = 32'd7;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst", {busy, done, quotient, remainder, dbz}, 0);
    reset = 1'b0;
    run32(32'd100, 32'd7, "postrst");

    // Reset and start together from IDLE
    @(negedge clk); reset = 1'b1; start = 1'b1; dividend = 32'd9; divisor = 32'd2;
    @(negedge clk);
    chk("rst+start", {busy, done, quotient}, 0);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst+start:idle", {busy, done}, 0);

    // Exhaustive small-width sweep
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        run4(WS'(a), WS'(b));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
